knn_top_k_selector: RTL and testbench

Streaming selector that sits directly downstream of `distance_calculator` in the KNN system. It consumes one (distance, class label) pair per cycle for a query and maintains a sorted list of the K smallest distances. After the last training sample it runs a sequential majority vote over the K labels and holds the predicted class and the sorted neighbour list until the next query starts.

---
 rtl/knn_top_k_selector.sv | 204 ++++++++++++++++++++
 tb/tb_knn_top_k_selector.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/knn_top_k_selector.sv
// knn_top_k_selector
//   Keeps the K nearest (distance, label) pairs of a streaming query in sorted
//   order, then runs a sequential majority vote over the kept labels.
//
// Ports
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   start            : one-cycle pulse, clears the list and opens a new query
//   in_valid/in_ready: sample handshake (in_ready high only while collecting)
//   in_dist/in_label : sample distance (unsigned) and class label
//   in_last          : marks the final sample of the query
//   busy             : collecting or voting
//   result_valid     : vote finished, results held until next start
//   result_label     : predicted class
//   result_count     : number of valid list entries
//   result_dists     : sorted distances, slot 0 (LSBs) nearest
//   result_labels    : labels aligned with result_dists
module knn_top_k_selector #(
  parameter int unsigned K  = 3,
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_dist,
  input  logic [LW-1:0]            in_label,
  input  logic                     in_last,
  output logic                     busy,
  output logic                     result_valid,
  output logic [LW-1:0]            result_label,
  output logic [$clog2(K+1)-1:0]   result_count,
  output logic [K*DW-1:0]          result_dists,
  output logic [K*LW-1:0]          result_labels
);

  localparam int unsigned CW = $clog2(K+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VOTE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0] r_dist [K];
  logic [LW-1:0] r_lab  [K];
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_vidx;
  logic [CW-1:0] r_best_cnt;
  logic [LW-1:0] r_best_lab;
  logic [LW-1:0] r_result_label;

  logic          w_accept;
  logic [CW-1:0] w_pos;
  logic [DW-1:0] w_ins_dist [K];
  logic [LW-1:0] w_ins_lab  [K];
  logic [CW-1:0] w_cnt_next;
  logic [LW-1:0] w_cand_lab;
  logic [CW-1:0] w_vcnt;
  logic          w_cand_ok;
  logic          w_vote_end;

  assign w_accept   = in_valid && (r_state == S_COLLECT);
  assign w_vote_end = (r_vidx == CW'(K));
  assign w_cand_ok  = (r_vidx < r_count);
  assign w_cnt_next = (r_count == CW'(K)) ? CW'(K) : r_count + 1'b1;

  // Insert position: valid slots with distance <= in_dist (ties stay nearer).
  always_comb begin
    w_pos = '0;
    for (int unsigned j = 0; j < K; j++) begin
      if ((CW'(j) < r_count) && (r_dist[j] <= in_dist)) begin
        w_pos = w_pos + 1'b1;
      end
    end
  end

  // Shifted list with the new sample placed at w_pos; old slot K-1 falls off.
  always_comb begin
    w_ins_dist[0] = (w_pos == '0) ? in_dist  : r_dist[0];
    w_ins_lab[0]  = (w_pos == '0) ? in_label : r_lab[0];
    for (int unsigned j = 1; j < K; j++) begin
      if (CW'(j) < w_pos) begin
        w_ins_dist[j] = r_dist[j];
        w_ins_lab[j]  = r_lab[j];
      end else if (CW'(j) == w_pos) begin
        w_ins_dist[j] = in_dist;
        w_ins_lab[j]  = in_label;
      end else begin
        w_ins_dist[j] = r_dist[j-1];
        w_ins_lab[j]  = r_lab[j-1];
      end
    end
  end

  // Vote candidate label and its occurrence count among valid slots.
  always_comb begin
    w_cand_lab = '0;
    for (int unsigned j = 0; j < K; j++) begin
      if (CW'(j) == r_vidx) begin
        w_cand_lab = r_lab[j];
      end
    end
    w_vcnt = '0;
    for (int unsigned j = 0; j < K; j++) begin
      if ((CW'(j) < r_count) && (r_lab[j] == w_cand_lab)) begin
        w_vcnt = w_vcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_COLLECT;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_IDLE;
        S_COLLECT: if (w_accept && in_last) w_next = S_VOTE;
        S_VOTE:    if (w_vote_end) w_next = S_DONE;
        S_DONE:    w_next = S_DONE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // VOTE walks candidates 0..K-1, then spends one more cycle (r_vidx == K)
  // committing the winner, giving a fixed K+1 cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < K; j++) begin
        r_dist[j] <= '0;
        r_lab[j]  <= '0;
      end
      r_count        <= '0;
      r_vidx         <= '0;
      r_best_cnt     <= '0;
      r_best_lab     <= '0;
      r_result_label <= '0;
    end else if (start) begin
      for (int unsigned j = 0; j < K; j++) begin
        r_dist[j] <= '0;
        r_lab[j]  <= '0;
      end
      r_count <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept && (w_pos < CW'(K))) begin
            for (int unsigned j = 0; j < K; j++) begin
              r_dist[j] <= w_ins_dist[j];
              r_lab[j]  <= w_ins_lab[j];
            end
            r_count <= w_cnt_next;
          end
          if (w_accept && in_last) begin
            r_vidx     <= '0;
            r_best_cnt <= '0;
            r_best_lab <= '0;
          end
        end
        S_VOTE: begin
          if (!w_vote_end) begin
            r_vidx <= r_vidx + 1'b1;
            if (w_cand_ok && (w_vcnt > r_best_cnt)) begin
              r_best_cnt <= w_vcnt;
              r_best_lab <= w_cand_lab;
            end
          end else begin
            r_result_label <= r_best_lab;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < K; j++) begin
      result_dists[j*DW +: DW]  = r_dist[j];
      result_labels[j*LW +: LW] = r_lab[j];
    end
  end

  assign in_ready     = (r_state == S_COLLECT);
  assign busy         = (r_state == S_COLLECT) || (r_state == S_VOTE);
  assign result_valid = (r_state == S_DONE);
  assign result_label = r_result_label;
  assign result_count = r_count;

endmodule

// File: tb/tb_knn_top_k_selector.sv
module tb_knn_top_k_selector;

  localparam int unsigned K  = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_dist;
  logic [LW-1:0]     in_label;
  logic              in_last;
  logic              busy;
  logic              result_valid;
  logic [LW-1:0]     result_label;
  logic [1:0]        result_count;
  logic [K*DW-1:0]   result_dists;
  logic [K*LW-1:0]   result_labels;

  int unsigned total = 0;
  int unsigned bad   = 0;

  knn_top_k_selector #(.K(K), .DW(DW), .LW(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dist       (in_dist),
    .in_label      (in_label),
    .in_last       (in_last),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_label  (result_label),
    .result_count  (result_count),
    .result_dists  (result_dists),
    .result_labels (result_labels)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] l, input logic last);
    in_valid = 1'b1;
    in_dist  = d;
    in_label = l;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, result_valid, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_dist  = '0;
    in_label = '0;
    in_last  = 1'b0;
    #12;
    chk("rst_count",  result_count, 2'd0);
    chk("rst_dists",  result_dists, 96'd0);
    chk("rst_valid",  result_valid, 1'b0);
    chk("rst_ready",  in_ready, 1'b0);
    #5 rst_n = 1'b1;
    tick();
    tick();
    chk("idle_ready", in_ready, 1'b0);
    chk("idle_busy",  busy, 1'b0);

    // Basic sort with exact latency
    do_start();
    chk("start_ready", in_ready, 1'b1);
    send(32'd50, 4'd1, 1'b0);
    send(32'd20, 4'd2, 1'b0);
    chk("partial_dists", result_dists, {32'd0, 32'd50, 32'd20});
    chk("partial_count", result_count, 2'd2);
    send(32'd80, 4'd3, 1'b0);
    send(32'd10, 4'd4, 1'b1);
    chk("basic_busy",  busy, 1'b1);
    chk("basic_ready", in_ready, 1'b0);
    tick(); tick(); tick();
    chk("basic_valid_early", result_valid, 1'b0);
    tick();
    chk("basic_valid_k1", result_valid, 1'b1);
    chk("basic_dists",  result_dists, {32'd50, 32'd20, 32'd10});
    chk("basic_labels", result_labels, {4'd1, 4'd2, 4'd4});
    chk("basic_count",  result_count, 2'd3);
    chk("basic_label",  result_label, 4'd4);
    chk("basic_busy_done", busy, 1'b0);
    tick(); tick();
    chk("basic_hold", result_label, 4'd4);

    // Ties
    do_start();
    chk("start_clears_valid", result_valid, 1'b0);
    send(32'd30, 4'd1, 1'b0);
    send(32'd30, 4'd2, 1'b0);
    send(32'd30, 4'd3, 1'b0);
    send(32'd30, 4'd4, 1'b1);
    wait_done("ties_done");
    chk("ties_labels", result_labels, {4'd3, 4'd2, 4'd1});
    chk("ties_label",  result_label, 4'd1);

    // Under-filled list
    do_start();
    send(32'd7, 4'd5, 1'b0);
    send(32'd3, 4'd5, 1'b1);
    wait_done("under_done");
    chk("under_count",  result_count, 2'd2);
    chk("under_dists",  result_dists, {32'd0, 32'd7, 32'd3});
    chk("under_labels", result_labels, {4'd0, 4'd5, 4'd5});
    chk("under_label",  result_label, 4'd5);

    // Majority, two arrival orders
    do_start();
    send(32'd5, 4'd1, 1'b0);
    send(32'd6, 4'd2, 1'b0);
    send(32'd7, 4'd2, 1'b1);
    wait_done("maj1_done");
    chk("maj1_label", result_label, 4'd2);
    do_start();
    send(32'd6, 4'd2, 1'b0);
    send(32'd7, 4'd2, 1'b0);
    send(32'd5, 4'd1, 1'b1);
    wait_done("maj2_done");
    chk("maj2_labels", result_labels, {4'd2, 4'd2, 4'd1});
    chk("maj2_label",  result_label, 4'd2);

    // Gaps between samples; large unsigned distance is discarded
    do_start();
    send(32'd50, 4'd1, 1'b0);
    tick(); tick();
    send(32'd20, 4'd2, 1'b0);
    tick();
    send(32'd80, 4'd3, 1'b0);
    send(32'hFFFF_FFFF, 4'd9, 1'b0);
    tick(); tick(); tick();
    send(32'd10, 4'd4, 1'b1);
    wait_done("gap_done");
    chk("gap_dists",  result_dists, {32'd50, 32'd20, 32'd10});
    chk("gap_labels", result_labels, {4'd1, 4'd2, 4'd4});
    chk("gap_label",  result_label, 4'd4);

    // Restart mid-COLLECT
    do_start();
    send(32'd1, 4'd7, 1'b0);
    send(32'd2, 4'd7, 1'b0);
    do_start();
    chk("restart_count", result_count, 2'd0);
    chk("restart_dists", result_dists, 96'd0);
    send(32'd9, 4'd3, 1'b0);
    send(32'd4, 4'd6, 1'b1);
    wait_done("restart_done");
    chk("restart_dists2",  result_dists, {32'd0, 32'd9, 32'd4});
    chk("restart_labels2", result_labels, {4'd0, 4'd3, 4'd6});
    chk("restart_label",   result_label, 4'd6);

    // Samples in DONE are ignored; start with in_valid in DONE drops the sample
    send(32'd1, 4'd8, 1'b0);
    chk("done_ignore_count", result_count, 2'd2);
    start    = 1'b1;
    in_valid = 1'b1;
    in_dist  = 32'd1;
    in_label = 4'd8;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_valid_count", result_count, 2'd0);
    chk("start_valid_ready", in_ready, 1'b1);
    chk("start_valid_rv",    result_valid, 1'b0);

    // Async reset during VOTE cycle 2
    send(32'd50, 4'd1, 1'b0);
    send(32'd20, 4'd2, 1'b0);
    send(32'd10, 4'd4, 1'b1);
    tick(); tick();
    chk("vote_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count",  result_count, 2'd0);
    chk("arst_dists",  result_dists, 96'd0);
    chk("arst_labels", result_labels, 12'd0);
    chk("arst_label",  result_label, 4'd0);
    chk("arst_busy",   busy, 1'b0);
    chk("arst_valid",  result_valid, 1'b0);
    #10 rst_n = 1'b1;
    tick(); tick(); tick();
    chk("arst_idle_ready", in_ready, 1'b0);
    do_start();
    chk("arst_start_ready", in_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
